// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg: ALUOp codes and mul/div state encodings shared by alu_mdu and mdu_core
package alu_mdu_pkg;
    localparam logic [4:0] ALUOp_ADDU  = 5'd0;
    localparam logic [4:0] ALUOp_SUBU  = 5'd1;
    localparam logic [4:0] ALUOp_ADD   = 5'd2;
    localparam logic [4:0] ALUOp_SUB   = 5'd3;
    localparam logic [4:0] ALUOp_AND   = 5'd4;
    localparam logic [4:0] ALUOp_OR    = 5'd5;
    localparam logic [4:0] ALUOp_SLT   = 5'd6;
    localparam logic [4:0] ALUOp_SLL   = 5'd7;
    localparam logic [4:0] ALUOp_SRL   = 5'd8;
    localparam logic [4:0] ALUOp_SRA   = 5'd9;
    localparam logic [4:0] ALUOp_LUI   = 5'd10;
    localparam logic [4:0] ALUOp_EQL   = 5'd11;
    localparam logic [4:0] ALUOp_BNE   = 5'd12;
    // bit1 = divide, bit0 = unsigned; mdu_core decodes these two bits directly
    localparam logic [4:0] ALUOp_MULT  = 5'd16;
    localparam logic [4:0] ALUOp_MULTU = 5'd17;
    localparam logic [4:0] ALUOp_DIV   = 5'd18;
    localparam logic [4:0] ALUOp_DIVU  = 5'd19;
    localparam logic [4:0] ALUOp_MFHI  = 5'd20;
    localparam logic [4:0] ALUOp_MFLO  = 5'd21;
    localparam logic [4:0] ALUOp_MTHI  = 5'd22;
    localparam logic [4:0] ALUOp_MTLO  = 5'd23;
    typedef enum logic [1:0] {MDU_IDLE, MDU_RUN, MDU_FIX} mdu_state_t;
endpackage

// File: rtl/alu_mdu_mdu_core.sv
// mdu_core: iterative radix-2 multiply/divide with sign correction
// ports: start/op/a/b launch an op in idle; done is high in FIX with hi_n/lo_n valid
import alu_mdu_pkg::*;
module mdu_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             idle,
    output logic             done,
    output logic [WIDTH-1:0] hi_n,
    output logic [WIDTH-1:0] lo_n
);
    localparam int CW = $clog2(WIDTH);
    mdu_state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [2*WIDTH-1:0] p, prod;
    logic [WIDTH-1:0] m, ma, mb, q, r;
    logic [WIDTH:0] sum, rs, diff;
    logic is_div, neg_q, neg_r, bz, sa, sb;
    assign sa = !op[0] && a[WIDTH-1];
    assign sb = !op[0] && b[WIDTH-1];
    assign ma = sa ? -a : a;
    assign mb = sb ? -b : b;
    // p holds {acc, multiplier} for multiply and {remainder, dividend} for divide
    assign sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? m : {WIDTH{1'b0}})};
    assign rs   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    assign diff = rs - {1'b0, m};
    assign prod = neg_q ? -p : p;
    assign q    = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    assign r    = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    // divide by zero naturally leaves the dividend as remainder; only the quotient needs forcing
    assign hi_n = is_div ? r : prod[2*WIDTH-1:WIDTH];
    assign lo_n = is_div ? (bz ? {WIDTH{1'b1}} : q) : prod[WIDTH-1:0];
    always_ff @(posedge clk) begin
        if (rst) state <= MDU_IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state == MDU_IDLE ? (start ? MDU_RUN : MDU_IDLE) :
                  state == MDU_RUN  ? (cnt == CW'(WIDTH-1) ? MDU_FIX : MDU_RUN) : MDU_IDLE;
    end
    always_comb begin
        idle = state == MDU_IDLE;
        done = state == MDU_FIX;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            p <= '0;
            m <= '0;
            cnt <= '0;
            is_div <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            bz <= 1'b0;
        end else if (state == MDU_IDLE && start) begin
            p <= {{WIDTH{1'b0}}, ma};
            m <= mb;
            cnt <= '0;
            is_div <= op[1];
            neg_q <= sa ^ sb;
            neg_r <= sa;
            bz <= b == '0;
        end else if (state == MDU_RUN) begin
            cnt <= cnt + 1'b1;
            p <= !is_div ? {sum, p[WIDTH-1:1]} :
                 diff[WIDTH] ? {rs[WIDTH-1:0], p[WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: registered EX-stage ALU with iterative mul/div and HI/LO registers
// ports: in_valid/in_ready handshake, ALUOp/A/B operands, C/zero/out_valid result, busy, hi/lo
import alu_mdu_pkg::*;
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       ALUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic             zero,
    output logic             out_valid,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    logic acc, is_md, done, z_n;
    logic [WIDTH-1:0] c_n, hi_n, lo_n;
    assign acc = in_valid && in_ready;
    assign is_md = ALUOp inside {ALUOp_MULT, ALUOp_MULTU, ALUOp_DIV, ALUOp_DIVU};
    assign busy = !in_ready;
    mdu_core #(.WIDTH(WIDTH)) u_mdu (
        .clk(clk), .rst(rst), .start(acc && is_md), .op(ALUOp[1:0]), .a(A), .b(B),
        .idle(in_ready), .done(done), .hi_n(hi_n), .lo_n(lo_n)
    );
    always_comb begin
        c_n = '0;
        z_n = 1'b0;
        case (ALUOp)
            ALUOp_ADDU, ALUOp_ADD: c_n = A + B;
            ALUOp_SUBU, ALUOp_SUB: c_n = A - B;
            ALUOp_AND:  c_n = A & B;
            ALUOp_OR:   c_n = A | B;
            ALUOp_SLT:  c_n = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            ALUOp_SLL:  c_n = B << A[SHW-1:0];
            ALUOp_SRL:  c_n = B >> A[SHW-1:0];
            ALUOp_SRA:  c_n = $signed(B) >>> A[SHW-1:0];
            ALUOp_LUI:  c_n = B << (WIDTH/2);
            ALUOp_EQL:  z_n = A == B;
            ALUOp_BNE:  z_n = A != B;
            ALUOp_MFHI: c_n = hi;
            ALUOp_MFLO: c_n = lo;
            ALUOp_MTHI, ALUOp_MTLO: c_n = A;
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            C <= '0;
            zero <= 1'b0;
            out_valid <= 1'b0;
            hi <= '0;
            lo <= '0;
        end else begin
            out_valid <= 1'b0;
            if (done) begin
                hi <= hi_n;
                lo <= lo_n;
                C <= lo_n;
                zero <= 1'b0;
                out_valid <= 1'b1;
            end else if (acc && !is_md) begin
                C <= c_n;
                zero <= z_n;
                out_valid <= 1'b1;
                if (ALUOp == ALUOp_MTHI) hi <= A;
                if (ALUOp == ALUOp_MTLO) lo <= A;
            end
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed self-checking bench for alu_mdu at WIDTH 32 and 16
import alu_mdu_pkg::*;
module tb_alu_mdu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_valid16 = 1'b0;
    logic [4:0] ALUOp = '0;
    logic [31:0] A = '0, B = '0;
    logic [31:0] C, hi, lo;
    logic zero, out_valid, in_ready, busy;
    logic [15:0] c16, hi16, lo16;
    logic zero16, ov16, rdy16, busy16;
    int n_tests = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    alu_mdu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ALUOp(ALUOp),
        .A(A), .B(B), .C(C), .zero(zero), .out_valid(out_valid), .busy(busy), .hi(hi), .lo(lo)
    );
    alu_mdu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(rdy16), .ALUOp(ALUOp),
        .A(A[15:0]), .B(B[15:0]), .C(c16), .zero(zero16), .out_valid(ov16), .busy(busy16),
        .hi(hi16), .lo(lo16)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // called at a negedge; the op is accepted on the next posedge and checked one negedge later
    task automatic sc(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ec, input logic ez, input string tag);
        ALUOp = op;
        A = a;
        B = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, " C"}, C, ec);
        check({tag, " zero"}, 32'(zero), 32'(ez));
        check({tag, " out_valid"}, 32'(out_valid), 1);
    endtask
    task automatic md(input bit s, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ehi, input logic [31:0] elo, input int elat, input string tag);
        int k, low;
        ALUOp = op;
        A = a;
        B = b;
        if (s) in_valid16 = 1'b1;
        else in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_valid16 = 1'b0;
        k = 0;
        low = 0;
        while (!(s ? ov16 : out_valid) && k < 200) begin
            if (!(s ? rdy16 : in_ready)) low++;
            @(negedge clk);
            k++;
        end
        check({tag, " latency"}, k, elat);
        check({tag, " ready_low"}, low, elat);
        check({tag, " ready_at_pulse"}, 32'(s ? rdy16 : in_ready), 1);
        check({tag, " hi"}, s ? {16'h0, hi16} : hi, ehi);
        check({tag, " lo"}, s ? {16'h0, lo16} : lo, elo);
        check({tag, " C"}, s ? {16'h0, c16} : C, elo);
        @(negedge clk);
    endtask
    initial begin
        int k, pulses;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst C", C, 0);
        check("rst zero", 32'(zero), 0);
        check("rst out_valid", 32'(out_valid), 0);
        check("rst hi", hi, 0);
        check("rst lo", lo, 0);
        check("rst in_ready", 32'(in_ready), 1);
        check("rst busy", 32'(busy), 0);
        sc(ALUOp_ADD, 32'd7, 32'hFFFF_FFFD, 32'd4, 1'b0, "add");
        sc(ALUOp_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, "slt");
        sc(ALUOp_BNE, 32'h55, 32'h55, 32'd0, 1'b0, "bne");
        sc(ALUOp_EQL, 32'h55, 32'h55, 32'd0, 1'b1, "eql");
        sc(ALUOp_SRA, 32'd4, 32'h8000_0000, 32'hF800_0000, 1'b0, "sra");
        sc(ALUOp_SRL, 32'd4, 32'h8000_0000, 32'h0800_0000, 1'b0, "srl");
        sc(ALUOp_SUBU, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, "subu");
        sc(ALUOp_SLL, 32'd36, 32'd1, 32'h10, 1'b0, "sll_mod");
        sc(ALUOp_LUI, 32'd0, 32'h1234, 32'h1234_0000, 1'b0, "lui");
        sc(5'd31, 32'd1, 32'd1, 32'd0, 1'b0, "unknown");
        @(negedge clk);
        check("hold out_valid", 32'(out_valid), 0);
        sc(ALUOp_MTHI, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1'b0, "mthi");
        sc(ALUOp_MTLO, 32'hCAFE_F00D, 32'd0, 32'hCAFE_F00D, 1'b0, "mtlo");
        sc(ALUOp_MFHI, 32'd0, 32'd0, 32'hDEAD_BEEF, 1'b0, "mfhi");
        sc(ALUOp_MFLO, 32'd0, 32'd0, 32'hCAFE_F00D, 1'b0, "mflo");
        @(negedge clk);
        md(1'b0, ALUOp_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 33, "mult");
        md(1'b0, ALUOp_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 33, "multu");
        md(1'b0, ALUOp_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, "div");
        md(1'b0, ALUOp_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 33, "divu0");
        md(1'b0, ALUOp_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 33, "div0neg");
        md(1'b0, ALUOp_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, "divmin");
        md(1'b0, ALUOp_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, "divu");
        ALUOp = ALUOp_MULT;
        A = 32'h0001_0001;
        B = 32'h0001_0000;
        in_valid = 1'b1;
        @(negedge clk);
        ALUOp = ALUOp_MFHI;
        k = 0;
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("stall latency", k, 33);
        check("stall C", C, 32'h0001_0000);
        check("stall ready", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("stall mfhi valid", 32'(out_valid), 1);
        check("stall mfhi C", C, 32'd1);
        ALUOp = ALUOp_DIV;
        A = 32'd100;
        B = 32'd7;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort hi", hi, 0);
        check("abort lo", lo, 0);
        check("abort ready", 32'(in_ready), 1);
        check("abort busy", 32'(busy), 0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("abort pulses", pulses, 0);
        md(1'b1, ALUOp_MULT, 32'h0000_FFFE, 32'd3, 32'h0000_FFFF, 32'h0000_FFFA, 17, "mult16");
        md(1'b1, ALUOp_DIV, 32'h0000_FFF9, 32'd2, 32'h0000_FFFF, 32'h0000_FFFD, 17, "div16");
        md(1'b1, ALUOp_MULTU, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFE, 32'd1, 17, "multu16");
        md(1'b1, ALUOp_DIVU, 32'd100, 32'd0, 32'd100, 32'h0000_FFFF, 17, "divu0_16");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
